// File: rtl/output_stream_tx_if.sv
// AXI-Stream style byte channel between the result transmitter and its sink.
interface output_stream_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/output_stream_tx.sv
// Result-stream transmitter: buffers core results in a FIFO and streams them out
// as AXI-Stream frames of FRAME_LEN beats, with an end-of-frame interrupt pulse.
module output_stream_tx #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_valid,
    output logic                o_ready,
    output_stream_tx_if.master  m_axis,
    output logic                o_intr,
    output logic                o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, last_q, overflow_q;
    logic [BW-1:0]     beat_q, beat_d;
    state_t            state_q, state_d;

    logic push, hs, hs_last, fifo_empty, load;

    // Acceptance depends on occupancy only, so a pop in the same cycle never frees a full FIFO.
    assign o_ready    = (count_q < CW'(DEPTH));
    assign push       = i_valid && o_ready;
    assign fifo_empty = (count_q == '0);
    assign hs         = valid_q && m_axis.ready;
    assign hs_last    = hs && last_q;
    // The frame's closing handshake and the DONE cycle both keep the output register empty.
    assign load       = (!valid_q || m_axis.ready) && !fifo_empty
                        && (state_q != DONE) && !hs_last;

    always_comb begin
        beat_d = beat_q;
        if (hs) begin
            beat_d = last_q ? '0 : beat_q + BW'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, load})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            beat_q  <= beat_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (i_valid && !o_ready) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem[rd_ptr_q];
                valid_q  <= 1'b1;
                last_q   <= (beat_d == BW'(FRAME_LEN - 1));
            end else if (hs) begin
                valid_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load)    state_d = SEND;
            SEND:    if (hs_last) state_d = DONE;
            DONE:    state_d = fifo_empty ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_intr = (state_q == DONE);
    end

    assign m_axis.data  = data_q;
    assign m_axis.valid = valid_q;
    assign m_axis.last  = last_q;
    assign o_overflow   = overflow_q;
endmodule
